// File: rtl/ps2_packet_framer.sv
// Frames the PS/2 mouse byte stream into 3-byte movement packets.
// A byte0 with bit 3 set starts a packet. A gap between bytes or a drop of enable abandons the partial packet.
module ps2_packet_framer #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter bit DROP_OVERFLOW  = 1'b1
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       enable,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       pkt_valid,
  output logic [8:0] dx,
  output logic [8:0] dy,
  output logic [2:0] buttons,
  output logic       x_ovf,
  output logic       y_ovf,
  output logic       sync_err,
  output logic [15:0] pkt_count
);

  localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_BYTE0,
    S_BYTE1,
    S_BYTE2
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        byte0_q;
  logic [7:0]        xbyte_q;
  logic [IDLE_W-1:0] idle_q;

  logic take_b0;
  logic take_x;
  logic deliver;
  logic bad_byte;
  logic timeout;

  logic [8:0] dx_new;
  logic [8:0] dy_new;

  // The Y byte is never stored: it is consumed on the same edge that publishes the packet.
  assign dx_new = (DROP_OVERFLOW && byte0_q[6]) ? 9'd0 : {byte0_q[4], xbyte_q};
  assign dy_new = (DROP_OVERFLOW && byte0_q[7]) ? 9'd0 : {byte0_q[5], rx_data};

  // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    take_b0  = 1'b0;
    take_x   = 1'b0;
    deliver  = 1'b0;
    bad_byte = 1'b0;
    timeout  = 1'b0;
    if (!enable) begin
      state_d = S_BYTE0;
    end else begin
      unique case (state_q)
        S_BYTE0: begin
          if (rx_valid) begin
            if (rx_data[3]) begin
              take_b0 = 1'b1;
              state_d = S_BYTE1;
            end else begin
              bad_byte = 1'b1;
            end
          end
        end
        S_BYTE1: begin
          if (rx_valid) begin
            take_x  = 1'b1;
            state_d = S_BYTE2;
          end else if (idle_q == IDLE_LAST) begin
            timeout = 1'b1;
            state_d = S_BYTE0;
          end
        end
        S_BYTE2: begin
          if (rx_valid) begin
            deliver = 1'b1;
            state_d = S_BYTE0;
          end else if (idle_q == IDLE_LAST) begin
            timeout = 1'b1;
            state_d = S_BYTE0;
          end
        end
        default: state_d = S_BYTE0;
      endcase
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_BYTE0;
    end else begin
      state_q <= state_d;
    end
  end

  // The idle counter runs only while a packet is partly received.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      idle_q <= '0;
    end else if (enable && !rx_valid && state_q != S_BYTE0 && state_d != S_BYTE0) begin
      idle_q <= idle_q + IDLE_W'(1);
    end else begin
      idle_q <= '0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      byte0_q   <= '0;
      xbyte_q   <= '0;
      pkt_valid <= 1'b0;
      sync_err  <= 1'b0;
      dx        <= '0;
      dy        <= '0;
      buttons   <= '0;
      x_ovf     <= 1'b0;
      y_ovf     <= 1'b0;
      pkt_count <= '0;
    end else begin
      pkt_valid <= deliver;
      sync_err  <= bad_byte | timeout;
      if (take_b0) byte0_q <= rx_data;
      if (take_x)  xbyte_q <= rx_data;
      if (deliver) begin
        dx        <= dx_new;
        dy        <= dy_new;
        buttons   <= byte0_q[2:0];
        x_ovf     <= byte0_q[6];
        y_ovf     <= byte0_q[7];
        pkt_count <= pkt_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_packet_framer.sv
// Directed bench for ps2_packet_framer. It runs two instances: one drops overflowed axes and one keeps them.
// Inputs change on the falling edge, and outputs are sampled on the falling edge.
module tb_ps2_packet_framer;

  logic        clock;
  logic        resetn;
  logic        enable;
  logic [7:0]  rx_data;
  logic        rx_valid;

  logic        pkt_valid, sync_err, x_ovf, y_ovf;
  logic [8:0]  dx, dy;
  logic [2:0]  buttons;
  logic [15:0] pkt_count;

  logic        nd_pkt_valid, nd_sync_err, nd_x_ovf, nd_y_ovf;
  logic [8:0]  nd_dx, nd_dy;
  logic [2:0]  nd_buttons;
  logic [15:0] nd_pkt_count;

  int n_checks = 0;
  int n_fail   = 0;
  int pv_cnt   = 0;
  int se_cnt   = 0;
  bit both_seen = 1'b0;

  ps2_packet_framer #(.TIMEOUT_CYCLES(100), .DROP_OVERFLOW(1'b1)) dut (
    .clock(clock), .resetn(resetn), .enable(enable), .rx_data(rx_data), .rx_valid(rx_valid),
    .pkt_valid(pkt_valid), .dx(dx), .dy(dy), .buttons(buttons), .x_ovf(x_ovf), .y_ovf(y_ovf),
    .sync_err(sync_err), .pkt_count(pkt_count)
  );

  ps2_packet_framer #(.TIMEOUT_CYCLES(100), .DROP_OVERFLOW(1'b0)) dut_nd (
    .clock(clock), .resetn(resetn), .enable(enable), .rx_data(rx_data), .rx_valid(rx_valid),
    .pkt_valid(nd_pkt_valid), .dx(nd_dx), .dy(nd_dy), .buttons(nd_buttons), .x_ovf(nd_x_ovf),
    .y_ovf(nd_y_ovf), .sync_err(nd_sync_err), .pkt_count(nd_pkt_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pulse monitor: reads the previous cycle's outputs on the rising edge.
  always @(posedge clock) begin
    if (pkt_valid) pv_cnt++;
    if (sync_err) se_cnt++;
    if (pkt_valid && sync_err) both_seen = 1'b1;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
  endtask

  task automatic test_reset;
    resetn = 1'b0; enable = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clock);
    n_checks++; if (pkt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pkt_valid got %b want 0", pkt_valid); end
    n_checks++; if (sync_err !== 1'b0) begin n_fail++; $display("FAIL reset_sync_err got %b want 0", sync_err); end
    n_checks++; if ({dx, dy} !== 18'd0) begin n_fail++; $display("FAIL reset_dxdy got %h/%h want 0/0", dx, dy); end
    n_checks++; if ({buttons, x_ovf, y_ovf} !== 5'd0) begin n_fail++; $display("FAIL reset_flags got %b want 0", {buttons, x_ovf, y_ovf}); end
    n_checks++; if (pkt_count !== 16'd0) begin n_fail++; $display("FAIL reset_count got %h want 0", pkt_count); end
    resetn = 1'b1;
    @(negedge clock);
    enable = 1'b1;
  endtask

  task automatic test_basic;
    int pv0;
    pv0 = pv_cnt;
    // Byte0 0x09 has the Y sign bit clear, so Y byte 0xFD reads as +253.
    send_packet(8'h09, 8'h05, 8'hFD);
    n_checks++; if (pkt_valid !== 1'b1) begin n_fail++; $display("FAIL basic_pkt_valid got %b want 1", pkt_valid); end
    n_checks++; if (dx !== 9'h005) begin n_fail++; $display("FAIL basic_dx got %h want 005", dx); end
    n_checks++; if (dy !== 9'h0FD) begin n_fail++; $display("FAIL basic_dy got %h want 0fd", dy); end
    n_checks++; if (buttons !== 3'b001) begin n_fail++; $display("FAIL basic_buttons got %b want 001", buttons); end
    n_checks++; if (pkt_count !== 16'd1) begin n_fail++; $display("FAIL basic_count got %0d want 1", pkt_count); end
    @(negedge clock);
    n_checks++; if (pkt_valid !== 1'b0) begin n_fail++; $display("FAIL basic_one_shot got %b want 0", pkt_valid); end
    n_checks++; if (dx !== 9'h005) begin n_fail++; $display("FAIL basic_hold_dx got %h want 005", dx); end
    // With the Y sign bit set (0x29), the same 0xFD reads as -3.
    send_packet(8'h29, 8'h05, 8'hFD);
    n_checks++; if (dy !== 9'h1FD) begin n_fail++; $display("FAIL basic_dy_neg got %h want 1fd", dy); end
    n_checks++; if (pkt_count !== 16'd2) begin n_fail++; $display("FAIL basic_count2 got %0d want 2", pkt_count); end
    repeat (2) @(negedge clock);
    n_checks++; if (pv_cnt - pv0 !== 2) begin n_fail++; $display("FAIL basic_pulses got %0d want 2", pv_cnt - pv0); end
  endtask

  task automatic test_resync;
    int se0, pv0;
    se0 = se_cnt; pv0 = pv_cnt;
    send_byte(8'h00);
    n_checks++; if (sync_err !== 1'b1) begin n_fail++; $display("FAIL resync_strobe got %b want 1", sync_err); end
    // Byte0 0x28: X sign clear (+16), Y sign set, so 0x20 reads as -224.
    send_packet(8'h28, 8'h10, 8'h20);
    n_checks++; if (dx !== 9'h010) begin n_fail++; $display("FAIL resync_dx got %h want 010", dx); end
    n_checks++; if (dy !== 9'h120) begin n_fail++; $display("FAIL resync_dy got %h want 120", dy); end
    n_checks++; if (buttons !== 3'b000) begin n_fail++; $display("FAIL resync_buttons got %b want 000", buttons); end
    repeat (2) @(negedge clock);
    n_checks++; if (se_cnt - se0 !== 1) begin n_fail++; $display("FAIL resync_err_count got %0d want 1", se_cnt - se0); end
    n_checks++; if (pv_cnt - pv0 !== 1) begin n_fail++; $display("FAIL resync_pkt_count got %0d want 1", pv_cnt - pv0); end
  endtask

  task automatic test_overflow;
    send_packet(8'h58, 8'h80, 8'h00);
    n_checks++; if (dx !== 9'h000) begin n_fail++; $display("FAIL ovf_x_drop got %h want 000", dx); end
    n_checks++; if ({x_ovf, y_ovf} !== 2'b10) begin n_fail++; $display("FAIL ovf_x_flags got %b want 10", {x_ovf, y_ovf}); end
    n_checks++; if (nd_dx !== 9'h180) begin n_fail++; $display("FAIL ovf_x_keep got %h want 180", nd_dx); end
    send_packet(8'hA8, 8'h01, 8'h02);
    n_checks++; if ({dx, dy} !== {9'h001, 9'h000}) begin n_fail++; $display("FAIL ovf_y_drop got %h/%h want 001/000", dx, dy); end
    n_checks++; if ({x_ovf, y_ovf} !== 2'b01) begin n_fail++; $display("FAIL ovf_y_flags got %b want 01", {x_ovf, y_ovf}); end
    n_checks++; if (nd_dy !== 9'h102) begin n_fail++; $display("FAIL ovf_y_keep got %h want 102", nd_dy); end
  endtask

  task automatic test_timeout;
    int se0, pv0;
    send_byte(8'h08);
    send_byte(8'h01);
    se0 = se_cnt; pv0 = pv_cnt;
    repeat (99) @(negedge clock);
    n_checks++; if (sync_err !== 1'b0 || se_cnt != se0) begin n_fail++; $display("FAIL timeout_early got %b/%0d want 0/0", sync_err, se_cnt - se0); end
    repeat (6) @(negedge clock);
    n_checks++; if (se_cnt - se0 !== 1) begin n_fail++; $display("FAIL timeout_err got %0d want 1", se_cnt - se0); end
    n_checks++; if (pv_cnt - pv0 !== 0) begin n_fail++; $display("FAIL timeout_no_pkt got %0d want 0", pv_cnt - pv0); end
    send_packet(8'h08, 8'h02, 8'h03);
    n_checks++; if ({pkt_valid, dx, dy} !== {1'b1, 9'h002, 9'h003}) begin n_fail++; $display("FAIL timeout_recover got %b %h %h want 1 002 003", pkt_valid, dx, dy); end
  endtask

  task automatic test_timeout_coincide;
    int se0;
    send_byte(8'h08);
    send_byte(8'h01);
    se0 = se_cnt;
    // The third byte is sampled on the same edge at which the idle counter sits at its terminal value.
    repeat (98) @(negedge clock);
    send_byte(8'h07);
    n_checks++; if ({pkt_valid, dx, dy} !== {1'b1, 9'h001, 9'h007}) begin n_fail++; $display("FAIL coincide_pkt got %b %h %h want 1 001 007", pkt_valid, dx, dy); end
    repeat (3) @(negedge clock);
    n_checks++; if (se_cnt - se0 !== 0) begin n_fail++; $display("FAIL coincide_no_err got %0d want 0", se_cnt - se0); end
  endtask

  task automatic test_reset_mid_packet;
    send_byte(8'h08);
    send_byte(8'h01);
    @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    n_checks++; if ({pkt_valid, sync_err, dx, dy, buttons, x_ovf, y_ovf} !== 25'd0) begin n_fail++; $display("FAIL midrst_outputs got %h want 0", {pkt_valid, sync_err, dx, dy, buttons, x_ovf, y_ovf}); end
    n_checks++; if (pkt_count !== 16'd0) begin n_fail++; $display("FAIL midrst_count got %0d want 0", pkt_count); end
    resetn = 1'b1;
    send_packet(8'h08, 8'h04, 8'h06);
    n_checks++; if ({pkt_valid, dx, dy} !== {1'b1, 9'h004, 9'h006}) begin n_fail++; $display("FAIL midrst_pkt got %b %h %h want 1 004 006", pkt_valid, dx, dy); end
    n_checks++; if (pkt_count !== 16'd1) begin n_fail++; $display("FAIL midrst_count_after got %0d want 1", pkt_count); end
  endtask

  task automatic test_wrap;
    int pv0;
    @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    pv0 = pv_cnt;
    for (int i = 0; i < 65535; i++) begin
      for (int j = 0; j < 3; j++) begin
        @(negedge clock);
        rx_valid = 1'b1;
        rx_data  = (j == 0) ? 8'h08 : 8'h00;
      end
    end
    @(negedge clock);
    rx_valid = 1'b0;
    n_checks++; if (pkt_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload got %h want ffff", pkt_count); end
    send_packet(8'h08, 8'h03, 8'h04);
    n_checks++; if ({pkt_valid, pkt_count} !== {1'b1, 16'h0000}) begin n_fail++; $display("FAIL wrap_rollover got %b %h want 1 0000", pkt_valid, pkt_count); end
    repeat (2) @(negedge clock);
    n_checks++; if (pv_cnt - pv0 !== 65536) begin n_fail++; $display("FAIL wrap_pulses got %0d want 65536", pv_cnt - pv0); end
  endtask

  task automatic test_enable_low;
    int se0, pv0;
    @(negedge clock);
    enable = 1'b0;
    se0 = se_cnt; pv0 = pv_cnt;
    send_packet(8'h08, 8'h01, 8'h02);
    send_byte(8'h00);
    send_packet(8'h09, 8'h07, 8'h07);
    repeat (3) @(negedge clock);
    n_checks++; if (pv_cnt - pv0 !== 0) begin n_fail++; $display("FAIL enlow_no_pkt got %0d want 0", pv_cnt - pv0); end
    n_checks++; if (se_cnt - se0 !== 0) begin n_fail++; $display("FAIL enlow_no_err got %0d want 0", se_cnt - se0); end
    n_checks++; if ({pkt_count, dx, dy} !== {16'h0000, 9'h003, 9'h004}) begin n_fail++; $display("FAIL enlow_hold got %h %h %h want 0000 003 004", pkt_count, dx, dy); end
  endtask

  task automatic test_enable_drop;
    int pv0, se0;
    enable = 1'b1;
    pv0 = pv_cnt; se0 = se_cnt;
    send_byte(8'h08);
    send_byte(8'h11);
    @(negedge clock);
    enable = 1'b0;
    @(negedge clock);
    enable = 1'b1;
    send_packet(8'h08, 8'h05, 8'h06);
    n_checks++; if ({pkt_valid, dx, dy} !== {1'b1, 9'h005, 9'h006}) begin n_fail++; $display("FAIL endrop_pkt got %b %h %h want 1 005 006", pkt_valid, dx, dy); end
    repeat (2) @(negedge clock);
    n_checks++; if ({pv_cnt - pv0, se_cnt - se0} !== {32'd1, 32'd0}) begin n_fail++; $display("FAIL endrop_pulses got %0d/%0d want 1/0", pv_cnt - pv0, se_cnt - se0); end
    n_checks++; if (pkt_count !== 16'd1) begin n_fail++; $display("FAIL endrop_count got %0d want 1", pkt_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_resync();
    test_overflow();
    test_timeout();
    test_timeout_coincide();
    test_reset_mid_packet();
    test_wrap();
    test_enable_low();
    test_enable_drop();
    n_checks++; if (both_seen !== 1'b0) begin n_fail++; $display("FAIL exclusive_strobes got %b want 0", both_seen); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
